// File: rtl/ahblite_bm_pkg.sv
// Shared AHB-Lite encodings and field widths for the bus-matrix output stage.
package ahblite_bm_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int HSIZE_W  = 3;
  localparam int HBURST_W = 3;
  localparam int HPROT_W  = 4;

  localparam logic [HBURST_W-1:0] HBURST_SINGLE = 3'b000;

  // True while the owner is inside a burst. The opening NONSEQ of a multi-beat
  // burst counts as well, otherwise the grant could move after beat 1.
  function automatic logic htrans_holds(input logic [1:0]          htrans,
                                        input logic [HBURST_W-1:0] hburst);
    return (htrans == HTRANS_BUSY) || (htrans == HTRANS_SEQ) ||
           ((htrans == HTRANS_NONSEQ) && (hburst != HBURST_SINGLE));
  endfunction

endpackage

// File: rtl/ahblite_busmatrix_rr_arbiter.sv
// Registered round-robin arbiter for one slave port. Holds the current owner
// while 'hold' is set or the bus is stalled; otherwise grants the next
// requester after the last winner.
//
//  state     | meaning
//  NOPORT    | own_vld=0, no input owns the address phase
//  OWNED(k)  | own_vld=1, own_idx=k drives the address phase
module ahblite_busmatrix_rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [NUM_IN-1:0] req,
  input  logic              hold,
  input  logic              hready,
  output logic              own_vld,
  output logic [IDX_W-1:0]  own_idx
);

  logic             own_vld_q, own_vld_d;
  logic [IDX_W-1:0] own_idx_q, own_idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic             found;
  logic [IDX_W-1:0] pick;

  // Two-pass scan: indices above last_idx first, then wrap; the last owner is checked last.
  always_comb begin
    found = 1'b0;
    pick  = last_idx_q;
    for (int j = 0; j < NUM_IN; j++) begin
      if (!found && req[j] && (IDX_W'(j) > last_idx_q)) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
    for (int j = 0; j < NUM_IN; j++) begin
      if (!found && req[j] && (IDX_W'(j) <= last_idx_q)) begin
        found = 1'b1;
        pick  = IDX_W'(j);
      end
    end
  end

  // Next-state: only re-arbitrate on a completed address phase outside a hold.
  always_comb begin
    own_vld_d  = own_vld_q;
    own_idx_d  = own_idx_q;
    last_idx_d = last_idx_q;
    if (hready && !hold) begin
      own_vld_d = found;
      if (found) begin
        own_idx_d  = pick;
        last_idx_d = pick;
      end
    end
  end

  // State registers; reset points last_idx at the top so port 0 wins first.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      own_vld_q  <= 1'b0;
      own_idx_q  <= '0;
      last_idx_q <= IDX_W'(NUM_IN - 1);
    end else begin
      own_vld_q  <= own_vld_d;
      own_idx_q  <= own_idx_d;
      last_idx_q <= last_idx_d;
    end
  end

  assign own_vld = own_vld_q;
  assign own_idx = own_idx_q;

endmodule

// File: rtl/ahblite_busmatrix_outputstage_rr.sv
// AHB-Lite bus-matrix output stage: NUM_IN input stages share one slave.
// Round-robin arbiter with burst hold, address-phase mux, data-phase owner
// tracking for HWDATA and slave-side HREADY.
// Optional macro OUTSTAGE_LOCK_EN: HMASTLOCK from the owner extends the grant
// and is forwarded to the slave; without it HMASTLOCK is tied low.
module ahblite_busmatrix_outputstage_rr
  import ahblite_bm_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic [NUM_IN-1:0]          HSEL_IN,
  input  logic [NUM_IN-1:0]          TRANS_HOLD_IN,
  input  logic [NUM_IN*ADDR_W-1:0]   HADDR_IN,
  input  logic [2*NUM_IN-1:0]        HTRANS_IN,
  input  logic [NUM_IN-1:0]          HWRITE_IN,
  input  logic [HSIZE_W*NUM_IN-1:0]  HSIZE_IN,
  input  logic [HBURST_W*NUM_IN-1:0] HBURST_IN,
  input  logic [HPROT_W*NUM_IN-1:0]  HPROT_IN,
  input  logic [NUM_IN-1:0]          HMASTLOCK_IN,
  input  logic [NUM_IN*DATA_W-1:0]   HWDATA_IN,
  input  logic                       HREADYOUT,
  output logic [NUM_IN-1:0]          ACTIVE_IN,
  output logic                       HSEL,
  output logic [ADDR_W-1:0]          HADDR,
  output logic [1:0]                 HTRANS,
  output logic                       HWRITE,
  output logic [HSIZE_W-1:0]         HSIZE,
  output logic [HBURST_W-1:0]        HBURST,
  output logic [HPROT_W-1:0]         HPROT,
  output logic                       HMASTLOCK,
  output logic                       HREADY,
  output logic [DATA_W-1:0]          HWDATA
);

  localparam int IDX_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0] req;
  logic              hold;
  logic              lock_own;
  logic              own_vld;
  logic [IDX_W-1:0]  own_idx;
  logic              dat_vld_q, dat_vld_d;
  logic [IDX_W-1:0]  dat_idx_q, dat_idx_d;

  assign req = HSEL_IN & TRANS_HOLD_IN;

  ahblite_busmatrix_rr_arbiter #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_arb (
    .hclk    (HCLK),
    .hreset  (HRESET),
    .req     (req),
    .hold    (hold),
    .hready  (HREADY),
    .own_vld (own_vld),
    .own_idx (own_idx)
  );

  // Address-phase mux: owner fields to the slave, everything low with no owner.
  always_comb begin
    ACTIVE_IN = '0;
    HSEL      = 1'b0;
    HADDR     = '0;
    HTRANS    = HTRANS_IDLE;
    HWRITE    = 1'b0;
    HSIZE     = '0;
    HBURST    = '0;
    HPROT     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (own_vld && (own_idx == IDX_W'(i))) begin
        ACTIVE_IN[i] = 1'b1;
        HSEL         = HSEL_IN[i];
        HADDR        = HADDR_IN[i*ADDR_W +: ADDR_W];
        HTRANS       = HTRANS_IN[i*2 +: 2];
        HWRITE       = HWRITE_IN[i];
        HSIZE        = HSIZE_IN[i*HSIZE_W +: HSIZE_W];
        HBURST       = HBURST_IN[i*HBURST_W +: HBURST_W];
        HPROT        = HPROT_IN[i*HPROT_W +: HPROT_W];
      end
    end
  end

`ifdef OUTSTAGE_LOCK_EN
  // Owner's lock request: forwarded to the slave and keeps the grant.
  always_comb begin
    lock_own = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (own_vld && (own_idx == IDX_W'(i))) lock_own = HMASTLOCK_IN[i];
    end
  end
  assign HMASTLOCK = lock_own;
`else
  logic unused_hmastlock_in;
  assign unused_hmastlock_in = ^HMASTLOCK_IN;
  assign lock_own  = 1'b0;
  assign HMASTLOCK = 1'b0;
`endif

  assign hold = own_vld & (htrans_holds(HTRANS, HBURST) | lock_own);

  assign HREADY = dat_vld_q ? HREADYOUT : 1'b1;

  // Write data follows whichever input owns the current data phase.
  always_comb begin
    HWDATA = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (dat_vld_q && (dat_idx_q == IDX_W'(i))) HWDATA = HWDATA_IN[i*DATA_W +: DATA_W];
    end
  end

  // Data-phase owner advances with each accepted address phase.
  always_comb begin
    dat_vld_d = dat_vld_q;
    dat_idx_d = dat_idx_q;
    if (HREADY) begin
      dat_vld_d = own_vld & HSEL;
      dat_idx_d = own_idx;
    end
  end

  // Data-phase registers; reset drops any in-flight data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dat_vld_q <= 1'b0;
      dat_idx_q <= '0;
    end else begin
      dat_vld_q <= dat_vld_d;
      dat_idx_q <= dat_idx_d;
    end
  end

endmodule
